// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// program-load write port, and the IF/ID pipeline register feeding decode.
module if_stage_fetch #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned AW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          br_taken,
    input  logic [31:0]   branch_addr,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_wdata,
    output logic [31:0]   pc,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instruction,
    output logic          if_valid
);

    localparam int unsigned ADDR_LSB = 2;
    localparam int unsigned HI_SHIFT = AW + ADDR_LSB;

    logic [31:0] r_mem [IMEM_WORDS];

    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instruction;
    logic        r_if_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic        w_out_of_range;
    logic [31:0] w_fetch_word;

    // Next sequential PC (wraps mod 2^32) and word-aligned branch target
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = branch_addr & ~32'h0000_0003;

    // Fetches above the memory footprint return a NOP
    assign w_out_of_range = |(r_pc >> HI_SHIFT);
    assign w_fetch_word   = w_out_of_range ? 32'h0 : r_mem[r_pc[AW+1:2]];

    // Program-load port; independent of reset, stall and branch so loading works in reset
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_addr] <= imem_wdata;
        end
    end

    // PC and IF/ID register: reset > branch flush > freeze hold > advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc             <= 32'h0;
            r_if_pc          <= 32'h0;
            r_if_instruction <= 32'h0;
            r_if_valid       <= 1'b0;
        end else if (br_taken) begin
            r_pc             <= w_branch_target;
            r_if_pc          <= 32'h0;
            r_if_instruction <= 32'h0;
            r_if_valid       <= 1'b0;
        end else if (!freeze) begin
            r_pc             <= w_pc_plus4;
            r_if_pc          <= w_pc_plus4;
            r_if_instruction <= w_fetch_word;
            r_if_valid       <= 1'b1;
        end
    end

    assign pc             = r_pc;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instruction;
    assign if_valid       = r_if_valid;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed test-plan steps followed by randomized traffic,
// all checked against a cycle-level reference model of the fetch stage.
module tb_if_stage_fetch;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] branch_addr;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_mem [1024];
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    logic        m_if_valid;

    logic [31:0] words [4];

    if_stage_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .br_taken       (br_taken),
        .branch_addr    (branch_addr),
        .imem_we        (imem_we),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs after the edge
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba,
                        input logic we, input logic [9:0] wa, input logic [31:0] wd);
        logic [31:0] fetched;
        rst = r; freeze = f; br_taken = b; branch_addr = ba;
        imem_we = we; imem_addr = wa; imem_wdata = wd;
        fetched = (m_pc < 32'd4096) ? m_mem[m_pc / 4] : 32'h0;
        if (!r) begin
            m_pc = 0; m_if_pc = 0; m_if_instr = 0; m_if_valid = 1'b0;
        end else if (b) begin
            m_pc = ba - (ba % 4); m_if_pc = 0; m_if_instr = 0; m_if_valid = 1'b0;
        end else if (!f) begin
            m_if_instr = fetched; m_if_pc = m_pc + 4; m_if_valid = 1'b1; m_pc = m_pc + 4;
        end
        if (we) m_mem[wa] = wd;
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("if_pc", if_pc, m_if_pc);
        chk("if_instruction", if_instruction, m_if_instr);
        chk("if_valid", 32'(if_valid), 32'(m_if_valid));
    endtask

    task automatic idle(input logic f);
        step(1'b1, f, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
    endtask

    task automatic branch(input logic f, input logic [31:0] ba);
        step(1'b1, f, 1'b1, ba, 1'b0, 10'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] held_instr, held_pc;
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; branch_addr = 32'h0;
        imem_we = 1'b0; imem_addr = 10'd0; imem_wdata = 32'h0;
        m_pc = 0; m_if_pc = 0; m_if_instr = 0; m_if_valid = 1'b0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h33333333; words[3] = 32'h44444444;

        // Program load while held in reset (random fill, then the test words)
        for (int i = 0; i < 1024; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'(i), $urandom);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 10'(i), words[i]);
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", 32'(if_valid), 32'h0);

        // Sequential fetch after release
        for (int k = 1; k <= 4; k++) begin
            idle(1'b0);
            chk("seq_instr", if_instruction, words[k-1]);
            chk("seq_if_pc", if_pc, 32'(4 * k));
            chk("seq_valid", 32'(if_valid), 32'h1);
        end

        // Reset again, advance two edges so IF/ID holds word 1, then freeze
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 10'd0, 32'h0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("frz_pc", pc, 32'h8);
            chk("frz_instr", if_instruction, 32'h22222222);
            chk("frz_if_pc", if_pc, 32'h8);
            chk("frz_valid", 32'(if_valid), 32'h1);
        end
        idle(1'b0);
        chk("unfrz_instr", if_instruction, 32'h33333333);
        chk("unfrz_pc", pc, 32'hC);

        // Branch flush at PC=12 to a misaligned target
        branch(1'b0, 32'h00000042);
        chk("br_pc", pc, 32'h40);
        chk("br_instr", if_instruction, 32'h0);
        chk("br_valid", 32'(if_valid), 32'h0);
        idle(1'b0);
        chk("br_tgt_instr", if_instruction, m_mem[16]);
        chk("br_tgt_if_pc", if_pc, 32'h44);

        // Branch while frozen redirects and flushes
        held_instr = if_instruction;
        branch(1'b1, 32'h00000100);
        chk("brfrz_pc", pc, 32'h100);
        chk("brfrz_valid", 32'(if_valid), 32'h0);

        // Reset dominates a simultaneous branch
        step(1'b0, 1'b1, 1'b1, 32'h00000200, 1'b0, 10'd0, 32'h0);
        chk("rstbr_pc", pc, 32'h0);
        chk("rstbr_valid", 32'(if_valid), 32'h0);
        idle(1'b0);
        chk("rst_release_instr", if_instruction, 32'h11111111);
        idle(1'b0);

        // Write/read collision at PC=8: fetch sees the old word
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 10'd2, 32'hDEADBEEF);
        chk("coll_old", if_instruction, 32'h33333333);
        branch(1'b0, 32'h8);
        idle(1'b0);
        chk("coll_new", if_instruction, 32'hDEADBEEF);

        // Out-of-range fetch and PC wrap
        branch(1'b0, 32'hFFFFFFFC);
        chk("oor_pc", pc, 32'hFFFFFFFC);
        idle(1'b0);
        chk("oor_instr", if_instruction, 32'h0);
        chk("oor_valid", 32'(if_valid), 32'h1);
        chk("wrap_pc", pc, 32'h0);
        idle(1'b0);
        chk("wrap_fetch", if_instruction, 32'h11111111);

        // Hold check through a freeze: outputs bit-identical
        held_instr = if_instruction;
        held_pc = if_pc;
        idle(1'b1);
        chk("hold_instr", if_instruction, held_instr);
        chk("hold_if_pc", if_pc, held_pc);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, f, b, we;
            logic [31:0] ba;
            r  = ($urandom_range(0, 49) != 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 2) == 0);
            ba = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            step(r, f, b, ba, we, 10'($urandom_range(0, 1023)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
